puzzle_move_sequencer: RTL and testbench

// - Owns the 3x3 sliding-puzzle board (8 tiles + blank) and applies exactly one legal move per debounced button press.
// - Loads a shuffled board from the randomiser, counts moves and flags the solved state.
// - Sits between the board randomiser/buttons and the 7-seg/VGA display logic.

---
 rtl/puzzle_pkg.sv | 42 ++++
 rtl/puzzle_tile_swap.sv | 48 ++++
 rtl/puzzle_move_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_puzzle_move_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared types and constants for the 3x3 sliding-puzzle move sequencer.
package puzzle_pkg;

  localparam int TILE_W = 4;

  localparam logic [11:0] GOAL_R1 = 12'h123;
  localparam logic [11:0] GOAL_R2 = 12'h456;
  localparam logic [11:0] GOAL_R3 = 12'h780;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PLAY   = 2'd1,
    S_MOVE   = 2'd2,
    S_SOLVED = 2'd3
  } state_e;

  // Cell k of the board is element k, row-major with 0 = top-left.
  typedef logic [8:0][TILE_W-1:0] board_t;

  function automatic board_t pack_rows(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    board_t t;
    for (int k = 0; k < 3; k++) begin
      t[k]     = a[11-4*k -: TILE_W];
      t[3 + k] = b[11-4*k -: TILE_W];
      t[6 + k] = c[11-4*k -: TILE_W];
    end
    return t;
  endfunction

  function automatic logic [11:0] row_of(input board_t t, input int r);
    return {t[3*r], t[3*r + 1], t[3*r + 2]};
  endfunction

endpackage

// File: rtl/puzzle_tile_swap.sv
// Combinational single-move engine: swaps the blank with its neighbour in direction dir.
module puzzle_tile_swap
  import puzzle_pkg::*;
(
  input  logic [11:0] row1_i,
  input  logic [11:0] row2_i,
  input  logic [11:0] row3_i,
  input  logic [3:0]  blank_i,
  input  dir_e        dir_i,
  output logic [11:0] row1_o,
  output logic [11:0] row2_o,
  output logic [11:0] row3_o,
  output logic [3:0]  blank_o,
  output logic        legal_o
);

  board_t     cur;
  board_t     nxt;
  logic [3:0] tgt;
  logic       legal;

  assign cur = pack_rows(row1_i, row2_i, row3_i);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    nxt     = cur;
    tgt     = blank_i;
    legal   = 1'b0;
    unique case (dir_i)
      DIR_L: begin legal = !(blank_i inside {4'd0, 4'd3, 4'd6}); tgt = blank_i - 4'd1; end
      DIR_R: begin legal = !(blank_i inside {4'd2, 4'd5, 4'd8}); tgt = blank_i + 4'd1; end
      DIR_U: begin legal = (blank_i >= 4'd3);                    tgt = blank_i - 4'd3; end
      DIR_D: begin legal = (blank_i <= 4'd5);                    tgt = blank_i + 4'd3; end
    endcase
    legal = legal && (blank_i <= 4'd8);
    if (legal) begin
      nxt[tgt]     = cur[blank_i];
      nxt[blank_i] = cur[tgt];
    end
  end

  assign row1_o  = row_of(nxt, 0);
  assign row2_o  = row_of(nxt, 1);
  assign row3_o  = row_of(nxt, 2);
  assign blank_o = legal ? tgt : blank_i;
  assign legal_o = legal;

endmodule

// File: rtl/puzzle_move_sequencer.sv
// Sliding-puzzle board owner: debounced buttons, one move per press, solve detection.
// Optional move budget / game_over port enabled by defining PUZZLE_MOVE_LIMIT_EN.
module puzzle_move_sequencer
  import puzzle_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYC = 20'd1000000,
  parameter int          MOVE_W       = 10
`ifdef PUZZLE_MOVE_LIMIT_EN
  ,
  parameter int          MAX_MOVES    = 200
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [11:0]       row1_in,
  input  logic [11:0]       row2_in,
  input  logic [11:0]       row3_in,
  input  logic              btn_l,
  input  logic              btn_r,
  input  logic              btn_u,
  input  logic              btn_d,
  output logic [11:0]       r1,
  output logic [11:0]       r2,
  output logic [11:0]       r3,
  output logic [3:0]        blank_pos,
  output logic [MOVE_W-1:0] move_count,
  output logic              solved,
  output logic              illegal,
  output logic              load_err
`ifdef PUZZLE_MOVE_LIMIT_EN
  ,
  output logic              game_over
`endif
);

  localparam logic [19:0] DB_LAST = DEBOUNCE_CYC - 20'd1;

  logic [3:0] btn;
  logic [3:0] press_evt;

  assign btn = {btn_d, btn_u, btn_r, btn_l};

  // Armed debouncers count consecutive highs; disarmed ones count consecutive lows.
  for (genvar g = 0; g < 4; g++) begin : g_db
    logic [19:0] cnt_q;
    logic        armed_q;
    logic        evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
        evt_q   <= 1'b0;
      end else begin
        evt_q <= 1'b0;
        if (btn[g] == armed_q) begin
          if (cnt_q == DB_LAST) begin
            cnt_q   <= '0;
            armed_q <= !armed_q;
            evt_q   <= armed_q;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign press_evt[g] = evt_q;
  end

  dir_e pick_dir;
  always_comb begin
    if      (press_evt[DIR_L]) pick_dir = DIR_L;
    else if (press_evt[DIR_R]) pick_dir = DIR_R;
    else if (press_evt[DIR_U]) pick_dir = DIR_U;
    else                       pick_dir = DIR_D;
  end

  board_t     ld_board;
  logic       zero_found;
  logic [3:0] zero_idx;

  assign ld_board = pack_rows(row1_in, row2_in, row3_in);

  // Scan downwards so the lowest-index blank wins.
  always_comb begin
    zero_found = 1'b0;
    zero_idx   = 4'd0;
    for (int k = 8; k >= 0; k--) begin
      if (ld_board[k] == '0) begin
        zero_found = 1'b1;
        zero_idx   = 4'(k);
      end
    end
  end

  state_e            state_q;
  dir_e              dir_q;
  logic [11:0]       r1_q, r2_q, r3_q;
  logic [3:0]        blank_q;
  logic [MOVE_W-1:0] count_q;
  logic              solved_q, illegal_q, load_err_q, chk_q;
  logic [11:0]       sw_r1, sw_r2, sw_r3;
  logic [3:0]        sw_blank;
  logic              sw_legal;
  logic              goal_hit;
  logic              limit_hit;

  puzzle_tile_swap u_swap (
    .row1_i  (r1_q),
    .row2_i  (r2_q),
    .row3_i  (r3_q),
    .blank_i (blank_q),
    .dir_i   (dir_q),
    .row1_o  (sw_r1),
    .row2_o  (sw_r2),
    .row3_o  (sw_r3),
    .blank_o (sw_blank),
    .legal_o (sw_legal)
  );

  assign goal_hit = (r1_q == GOAL_R1) && (r2_q == GOAL_R2) && (r3_q == GOAL_R3);

`ifdef PUZZLE_MOVE_LIMIT_EN
  logic game_over_q;
  assign limit_hit = (count_q == MOVE_W'(MAX_MOVES));
  assign game_over = game_over_q;
`else
  assign limit_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      dir_q      <= DIR_L;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      blank_q    <= '0;
      count_q    <= '0;
      solved_q   <= 1'b0;
      illegal_q  <= 1'b0;
      load_err_q <= 1'b0;
      chk_q      <= 1'b0;
`ifdef PUZZLE_MOVE_LIMIT_EN
      game_over_q <= 1'b0;
`endif
    end else begin
      illegal_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (load) begin
        r1_q     <= row1_in;
        r2_q     <= row2_in;
        r3_q     <= row3_in;
        count_q  <= '0;
        solved_q <= 1'b0;
        chk_q    <= 1'b0;
`ifdef PUZZLE_MOVE_LIMIT_EN
        game_over_q <= 1'b0;
`endif
        blank_q  <= zero_idx;
        if (zero_found) begin
          state_q <= S_PLAY;
        end else begin
          load_err_q <= 1'b1;
          state_q    <= S_EMPTY;
        end
      end else begin
        unique case (state_q)
          S_EMPTY, S_SOLVED: ;
          S_PLAY: begin
            chk_q <= 1'b0;
            // Solve/budget checks look at the board registered by the previous move.
            if (chk_q && goal_hit) begin
              solved_q <= 1'b1;
              state_q  <= S_SOLVED;
            end else if (chk_q && limit_hit) begin
`ifdef PUZZLE_MOVE_LIMIT_EN
              game_over_q <= 1'b1;
`endif
              state_q <= S_SOLVED;
            end else if (|press_evt) begin
              dir_q   <= pick_dir;
              state_q <= S_MOVE;
            end
          end
          S_MOVE: begin
            if (sw_legal) begin
              r1_q    <= sw_r1;
              r2_q    <= sw_r2;
              r3_q    <= sw_r3;
              blank_q <= sw_blank;
              if (count_q != '1) count_q <= count_q + 1'b1;
              chk_q   <= 1'b1;
            end else begin
              illegal_q <= 1'b1;
            end
            state_q <= S_PLAY;
          end
        endcase
      end
    end
  end

  assign r1         = r1_q;
  assign r2         = r2_q;
  assign r3         = r3_q;
  assign blank_pos  = blank_q;
  assign move_count = count_q;
  assign solved     = solved_q;
  assign illegal    = illegal_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_puzzle_move_sequencer.sv
// Self-checking bench for puzzle_move_sequencer: directed scenarios plus random games vs a board model.
module tb_puzzle_move_sequencer;

  localparam int MW = 4;
`ifdef PUZZLE_MOVE_LIMIT_EN
  localparam int MAXM = 3;
`endif

  logic          clk, rst_n, load;
  logic [11:0]   row1_in, row2_in, row3_in;
  logic          btn_l, btn_r, btn_u, btn_d;
  logic [11:0]   r1, r2, r3;
  logic [3:0]    blank_pos;
  logic [MW-1:0] move_count;
  logic          solved, illegal, load_err;
`ifdef PUZZLE_MOVE_LIMIT_EN
  logic          game_over;
`endif

  puzzle_move_sequencer #(
    .DEBOUNCE_CYC (20'd4),
    .MOVE_W       (MW)
`ifdef PUZZLE_MOVE_LIMIT_EN
    ,
    .MAX_MOVES    (MAXM)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .row1_in    (row1_in),
    .row2_in    (row2_in),
    .row3_in    (row3_in),
    .btn_l      (btn_l),
    .btn_r      (btn_r),
    .btn_u      (btn_u),
    .btn_d      (btn_d),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .blank_pos  (blank_pos),
    .move_count (move_count),
    .solved     (solved),
    .illegal    (illegal),
    .load_err   (load_err)
`ifdef PUZZLE_MOVE_LIMIT_EN
    ,
    .game_over  (game_over)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: tile values per cell, plus bookkeeping of the game.
  int m[9];
  int mblank, mcount;
  bit msolved, mgo, mactive;
  int exp_ill  = 0;
  int exp_lerr = 0;
  int obs_ill  = 0;
  int obs_lerr = 0;

  always @(negedge clk) begin
    if (illegal === 1'b1)  obs_ill++;
    if (load_err === 1'b1) obs_lerr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] m_row(input int r);
    logic [3:0] a, b, c;
    a = 4'(m[3*r]);
    b = 4'(m[3*r + 1]);
    c = 4'(m[3*r + 2]);
    return {a, b, c};
  endfunction

  function automatic bit m_is_goal();
    for (int k = 0; k < 8; k++) if (m[k] != k + 1) return 1'b0;
    return (m[8] == 0);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 9; k++) m[k] = 0;
    mblank = 0; mcount = 0; msolved = 0; mgo = 0; mactive = 0;
  endtask

  task automatic m_load(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    logic [35:0] all;
    bit found;
    all = {a, b, c};
    found = 0;
    mblank = 0;
    for (int k = 0; k < 9; k++) begin
      m[k] = int'(all[35-4*k -: 4]);
      if (!found && m[k] == 0) begin found = 1; mblank = k; end
    end
    mcount = 0; msolved = 0; mgo = 0; mactive = found;
    if (!found) exp_lerr++;
  endtask

  // d: 0=L 1=R 2=U 3=D
  task automatic m_press(input int d);
    int row, col, t, tmp;
    if (!mactive) return;
    row = mblank / 3;
    col = mblank % 3;
    case (d)
      0: col = col - 1;
      1: col = col + 1;
      2: row = row - 1;
      default: row = row + 1;
    endcase
    if (row < 0 || row > 2 || col < 0 || col > 2) begin
      exp_ill++;
    end else begin
      t = row * 3 + col;
      tmp = m[t]; m[t] = m[mblank]; m[mblank] = tmp;
      mblank = t;
      if (mcount < (1 << MW) - 1) mcount++;
      if (m_is_goal()) begin
        msolved = 1; mactive = 0;
      end
`ifdef PUZZLE_MOVE_LIMIT_EN
      else if (mcount == MAXM) begin
        mgo = 1; mactive = 0;
      end
`endif
    end
  endtask

  task automatic m_press_mask(input logic [3:0] mk);
    for (int d = 0; d < 4; d++) if (mk[d]) begin m_press(d); return; end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".r1"},      32'(r1),         32'(m_row(0)));
    check({tag, ".r2"},      32'(r2),         32'(m_row(1)));
    check({tag, ".r3"},      32'(r3),         32'(m_row(2)));
    check({tag, ".blank"},   32'(blank_pos),  32'(mblank));
    check({tag, ".count"},   32'(move_count), 32'(mcount));
    check({tag, ".solved"},  32'(solved),     32'(msolved));
    check({tag, ".illegal"}, 32'(obs_ill),    32'(exp_ill));
    check({tag, ".lderr"},   32'(obs_lerr),   32'(exp_lerr));
`ifdef PUZZLE_MOVE_LIMIT_EN
    check({tag, ".gover"},   32'(game_over),  32'(mgo));
`endif
  endtask

  task automatic drive_btn(input logic [3:0] mk);
    {btn_d, btn_u, btn_r, btn_l} = mk;
  endtask

  task automatic do_load(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
    @(negedge clk);
    load = 1'b1; row1_in = a; row2_in = b; row3_in = c;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    m_load(a, b, c);
  endtask

  task automatic press(input logic [3:0] mk, input int hold);
    @(negedge clk);
    drive_btn(mk);
    repeat (hold) @(negedge clk);
    drive_btn(4'b0000);
    repeat (10) @(negedge clk);
    if (hold >= 4) m_press_mask(mk);
  endtask

  initial begin
    int p[9];
    logic [35:0] pk;
    logic [3:0] mk;
    bit found;

    rst_n = 1'b0; load = 1'b0;
    row1_in = '0; row2_in = '0; row3_in = '0;
    drive_btn(4'b0000);
    m_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;

    press(4'b0001, 6);
    check_state("empty_ignore");

    // Winning move: board visible first, solved one cycle later.
    do_load(12'h123, 12'h456, 12'h708);
    check_state("t1.load");
    @(negedge clk);
    drive_btn(4'b0010);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (r3 === 12'h780) found = 1;
    end
    check("t1.seen", 32'(found), 32'd1);
    check("t1.solved_lag", 32'(solved), 32'd0);
    @(negedge clk);
    check("t1.solved_rise", 32'(solved), 32'd1);
    drive_btn(4'b0000);
    repeat (10) @(negedge clk);
    m_press(1);
    check_state("t1.final");
    press(4'b0001, 5);
    check_state("t1.frozen");

    do_load(12'h123, 12'h456, 12'h780);
    press(4'b1000, 5);
    check_state("edge_down");
    press(4'b0100, 5);
    check_state("up_after_illegal");

    do_load(12'h123, 12'h405, 12'h786);
    press(4'b0001, 50);
    check_state("hold_l");

    do_load(12'h123, 12'h405, 12'h786);
    press(4'b0101, 5);
    check_state("u_and_l");

    do_load(12'h123, 12'h456, 12'h789);
    check_state("no_blank");
    press(4'b0001, 5);
    check_state("no_blank_press");

    // Alternating moves: saturates the counter (or hits the move budget).
    do_load(12'h123, 12'h405, 12'h786);
    for (int i = 0; i < 18; i++) begin
      press((i % 2 == 0) ? 4'b0001 : 4'b0010, 5);
      check_state($sformatf("alt%0d", i));
    end

    for (int rnd = 0; rnd < 5; rnd++) begin
      for (int k = 0; k < 9; k++) p[k] = k;
      for (int k = 8; k > 0; k--) begin
        int j, t;
        j = int'($urandom_range(k, 0));
        t = p[k]; p[k] = p[j]; p[j] = t;
      end
      for (int k = 0; k < 9; k++) pk[35-4*k -: 4] = 4'(p[k]);
      do_load(pk[35:24], pk[23:12], pk[11:0]);
      check_state($sformatf("rnd%0d.load", rnd));
      for (int s = 0; s < 10; s++) begin
        if ($urandom_range(3, 0) == 0) mk = 4'($urandom_range(15, 1));
        else mk = 4'b0001 << $urandom_range(3, 0);
        press(mk, int'($urandom_range(8, 5)));
        check_state($sformatf("rnd%0d.s%0d", rnd, s));
      end
    end

    // Reset asserted while the move is in flight.
    do_load(12'h123, 12'h405, 12'h786);
    @(negedge clk);
    drive_btn(4'b0001);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    check("rst.r1", 32'(r1), 32'd0);
    check("rst.r2", 32'(r2), 32'd0);
    check("rst.blank", 32'(blank_pos), 32'd0);
    check("rst.count", 32'(move_count), 32'd0);
    drive_btn(4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_state("rst.after");
    press(4'b0010, 5);
    check_state("rst.ignore");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
